sliding_puzzle_core: RTL
========================

Name: sliding_puzzle_core

Overview:
Parametrised R x C sliding-tile puzzle engine. It is the successor of the fixed 2x2 game datapath.
- Holds the board and accepts manual board loads or generates guaranteed-solvable boards by random legal shuffling.
- Applies one-hot player moves, counts moves and flags a win.
- Sits between the button/switch front end (debounced `act`, `start`, `shuffle`) and the display/LED driver, all on the divided game clock `clk_d`.

Parameters:
ROWS, 3, board rows (2..4)
COLS, 3, board columns (2..4)
TW, 4, bits per tile code; must satisfy 2**TW >= ROWS*COLS
SHUF_MOVES, 64, legal random moves applied per shuffle (1..255)
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit shuffle LFSR

Ports:
clk_d  in  1  game clock
rst  in  1  reset, asynchronous, active-high
load_en  in  1  write load_tile into cell load_idx (IDLE only)
load_idx  in  TW  cell index; row-major, 0 = top-left
load_tile  in  TW  tile code; code N-1 (N=ROWS*COLS) is the blank
start  in  1  validate the loaded board and begin play
shuffle  in  1  reset to the solved board and randomly shuffle it
abort  in  1  return to IDLE, board kept
act  in  4  move request for the blank: [3]=left, [2]=down, [1]=right, [0]=up
busy  out  1  high in FIND and SHUFFLE
ini_flag  out  1  one-cycle pulse on entry to PLAY
bad_move  out  1  one-cycle pulse on a rejected act in PLAY
load_err  out  1  sticky; set by a failed FIND, cleared by the next start or shuffle
win_flag  out  1  high while in WON
blank_pos  out  TW  current blank cell index
move_count  out  16  moves since entering PLAY, saturating at 16'hFFFF
out_game  out  N*TW  board, cell 0 in MSBs, cell N-1 in LSBs

Behaviour:
- Reset values:
  - Board solved: cell i holds code i. blank_pos = N-1. State IDLE.
  - All pulse/flag outputs 0. move_count = 0. LFSR = LFSR_SEED.
- Control priority in a single cycle: abort > shuffle > start > load_en. A command arriving in a state that does not accept it is ignored.
- LFSR: x^16+x^14+x^13+x^11, free-running every cycle in every state.
- IDLE:
  - load_en writes the cell next cycle; load_idx >= N is ignored.
  - start -> FIND.
  - shuffle -> SHUFFLE.
- FIND:
  - Scans cells 0..N-1, one per cycle, counting blanks.
  - After cell N-1: exactly one blank -> PLAY with blank_pos set, move_count=0, ini_flag pulse. Latency from start is N+1 cycles.
  - Zero or more than one blank -> load_err=1, return to IDLE.
  - Duplicate non-blank codes are not checked.
- SHUFFLE:
  - Entry cycle loads the solved board and sets blank_pos=N-1.
  - Each following cycle, the direction is taken from lfsr[1:0] (00 up, 01 right, 10 down, 11 left).
  - The move is skipped if it goes off the edge or exactly reverses the previous applied move. Otherwise the blank swaps with that neighbour and the applied-move counter increments.
  - After SHUF_MOVES applied moves -> PLAY, ini_flag pulse, move_count=0.
  - abort mid-shuffle -> IDLE, partially shuffled board kept.
- PLAY:
  - act=0: no action.
  - act exactly one-hot and the target lies inside the grid: the blank swaps with the neighbour in the same cycle edge; blank_pos and move_count update together.
  - act not one-hot, or target off-edge (row 0 up, row R-1 down, col 0 left, col C-1 right): board unchanged, bad_move pulses the next cycle.
  - act is level-sampled every cycle. The front end supplies one-cycle pulses.
  - The solved-board compare is registered. On the cycle after the board becomes solved -> WON. An act arriving in that one cycle is ignored.
  - start and shuffle are ignored in PLAY; abort -> IDLE.
- WON:
  - win_flag=1; act ignored; board and move_count frozen.
  - shuffle -> SHUFFLE; start -> FIND; abort -> IDLE.
  - win_flag clears on leaving.
- Async rst mid-FIND, mid-SHUFFLE or mid-PLAY: immediately returns all state to the reset values.

Decomposition:
- Package `puzzle_pkg`:
  - State enum: IDLE, FIND, SHUFFLE, PLAY, WON.
  - Direction constants: DIR_UP=4'b0001, DIR_RIGHT=4'b0010, DIR_DOWN=4'b0100, DIR_LEFT=4'b1000.
  - Function returning the neighbour index and a valid bit for (pos, dir, ROWS, COLS).
- Sub-module `puzzle_lfsr`: 16-bit Fibonacci LFSR with seed parameter; output is the current state.

Test Plan:
- Reset, 3x3 -> out_game = 0,1,..,8 (36'h012345678), blank_pos=8, state IDLE, all flags 0.
- Load cells 0..8 with 0,1,2,3,8,5,6,4,7; pulse start -> ini_flag exactly 10 cycles later, blank_pos=4. Then act=DOWN -> blank_pos=7. Then act=RIGHT -> blank_pos=8, win_flag=1 one cycle later, move_count=2.
- In PLAY with blank_pos=8: act=DOWN -> bad_move pulse, board unchanged, move_count unchanged. act=4'b0011 -> bad_move pulse.
- Load all cells with code 0 and start -> load_err=1 after N+1 cycles, back in IDLE. Then start with a valid board -> load_err clears.
- shuffle with SHUF_MOVES=64 -> busy high at least 65 cycles, then ini_flag. Final board is a permutation of 0..8 with exactly one blank and blank_pos matching it. Replay of the applied moves from solved matches the bench model.
- Assert rst mid-SHUFFLE and hold with act stimulus applied -> outputs equal the reset values immediately, not waiting for a clock edge.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types, direction encodings and grid-neighbour helpers for the sliding puzzle.
package puzzle_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFind,
        StShuffle,
        StPlay,
        StWon
    } state_e;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    // Grids are at most 4x4, so any cell index fits in four bits.
    localparam int unsigned IDX_W = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } nbr_t;

    // Neighbour of cell pos in direction dir; valid is low for off-grid or non-one-hot dir.
    function automatic nbr_t neighbour(input int unsigned pos, input logic [3:0] dir,
                                       input int unsigned rows, input int unsigned cols);
        nbr_t        res;
        int unsigned row;
        int unsigned col;
        row       = pos / cols;
        col       = pos % cols;
        res.valid = 1'b0;
        res.idx   = IDX_W'(pos);
        case (dir)
            DIR_UP: begin
                if (row > 0) begin
                    res.valid = 1'b1;
                    res.idx   = IDX_W'(pos - cols);
                end
            end
            DIR_RIGHT: begin
                if (col + 1 < cols) begin
                    res.valid = 1'b1;
                    res.idx   = IDX_W'(pos + 1);
                end
            end
            DIR_DOWN: begin
                if (row + 1 < rows) begin
                    res.valid = 1'b1;
                    res.idx   = IDX_W'(pos + cols);
                end
            end
            DIR_LEFT: begin
                if (col > 0) begin
                    res.valid = 1'b1;
                    res.idx   = IDX_W'(pos - 1);
                end
            end
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

    // Opposite direction: up<->down, left<->right.
    function automatic logic [3:0] reverse_dir(input logic [3:0] dir);
        return {dir[1:0], dir[3:2]};
    endfunction

endpackage

// File: rtl/puzzle_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11.
module puzzle_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_d,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;

    // Shift left every cycle, feedback enters at bit 0.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/sliding_puzzle_core.sv
// R x C sliding-tile puzzle engine: board load/validate, random shuffle, play and win detect.
module sliding_puzzle_core
    import puzzle_pkg::*;
#(
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 3,
    parameter int unsigned TW         = 4,
    parameter int unsigned SHUF_MOVES = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk_d,
    input  logic                      rst,
    input  logic                      load_en,
    input  logic [TW-1:0]             load_idx,
    input  logic [TW-1:0]             load_tile,
    input  logic                      start,
    input  logic                      shuffle,
    input  logic                      abort,
    input  logic [3:0]                act,
    output logic                      busy,
    output logic                      ini_flag,
    output logic                      bad_move,
    output logic                      load_err,
    output logic                      win_flag,
    output logic [TW-1:0]             blank_pos,
    output logic [15:0]               move_count,
    output logic [ROWS*COLS*TW-1:0]   out_game
);

    localparam int unsigned N = ROWS * COLS;
    localparam logic [TW-1:0] BLANK = TW'(N - 1);

    state_e      state_q, state_d;
    logic [TW-1:0] board_q [N];
    logic [TW-1:0] board_d [N];
    logic [TW-1:0] blank_q, blank_d;
    logic [15:0]   move_cnt_q, move_cnt_d;
    logic          ini_q, ini_d;
    logic          bad_q, bad_d;
    logic          err_q, err_d;
    logic [TW-1:0] scan_q, scan_d;
    logic [1:0]    bcnt_q, bcnt_d;     // blanks seen so far, saturates at 2
    logic [TW-1:0] fpos_q, fpos_d;
    logic          shuf_load_q, shuf_load_d;
    logic [7:0]    shuf_cnt_q, shuf_cnt_d;
    logic [3:0]    prev_q, prev_d;     // last applied shuffle move, 0 = none

    logic [15:0] lfsr;
    logic        unused_lfsr;
    logic [3:0]  shuf_dir;
    logic [3:0]  mv_dir;
    nbr_t        nb;
    logic        solved;
    logic        do_swap;
    logic        cmd_find;
    logic        cmd_shuf;

    puzzle_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_d (clk_d),
        .rst   (rst),
        .lfsr  (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:2];
    assign shuf_dir    = 4'b0001 << lfsr[1:0];
    assign mv_dir      = (state_q == StShuffle) ? shuf_dir : act;
    assign nb          = neighbour(32'(blank_q), mv_dir, ROWS, COLS);

    // Board equals the solved arrangement (cell i holds code i).
    always_comb begin
        solved = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (board_q[i] != TW'(i)) solved = 1'b0;
        end
    end

    // Next-state and datapath decode for the game FSM.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        blank_d     = blank_q;
        move_cnt_d  = move_cnt_q;
        ini_d       = 1'b0;
        bad_d       = 1'b0;
        err_d       = err_q;
        scan_d      = scan_q;
        bcnt_d      = bcnt_q;
        fpos_d      = fpos_q;
        shuf_load_d = shuf_load_q;
        shuf_cnt_d  = shuf_cnt_q;
        prev_d      = prev_q;
        do_swap     = 1'b0;
        cmd_find    = 1'b0;
        cmd_shuf    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (shuffle) begin
                    cmd_shuf = 1'b1;
                end else if (start) begin
                    cmd_find = 1'b1;
                end else if (load_en && (32'(load_idx) < N)) begin
                    board_d[load_idx] = load_tile;
                end
            end
            StFind: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (board_q[scan_q] == BLANK) begin
                        fpos_d = scan_q;
                        if (bcnt_q != 2'd2) bcnt_d = bcnt_q + 2'd1;
                    end
                    if (32'(scan_q) == N - 1) begin
                        if (bcnt_d == 2'd1) begin
                            state_d    = StPlay;
                            blank_d    = fpos_d;
                            move_cnt_d = '0;
                            ini_d      = 1'b1;
                        end else begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end
            end
            StShuffle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (shuf_load_q) begin
                    for (int i = 0; i < N; i++) board_d[i] = TW'(i);
                    blank_d     = BLANK;
                    shuf_cnt_d  = '0;
                    prev_d      = '0;
                    shuf_load_d = 1'b0;
                end else if (nb.valid && (mv_dir != reverse_dir(prev_q))) begin
                    do_swap    = 1'b1;
                    prev_d     = mv_dir;
                    shuf_cnt_d = shuf_cnt_q + 8'd1;
                    if (32'(shuf_cnt_q) + 1 == SHUF_MOVES) begin
                        state_d    = StPlay;
                        move_cnt_d = '0;
                        ini_d      = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (solved) begin
                    // Registered win compare: acts in this cycle are dropped.
                    state_d = StWon;
                end else if (act != 4'b0000) begin
                    if ($onehot(act) && nb.valid) begin
                        do_swap = 1'b1;
                        if (move_cnt_q != 16'hFFFF) move_cnt_d = move_cnt_q + 16'd1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            StWon: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (shuffle) begin
                    cmd_shuf = 1'b1;
                end else if (start) begin
                    cmd_find = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (cmd_shuf) begin
            state_d     = StShuffle;
            shuf_load_d = 1'b1;
            err_d       = 1'b0;
        end
        if (cmd_find) begin
            state_d = StFind;
            scan_d  = '0;
            bcnt_d  = '0;
            fpos_d  = '0;
            err_d   = 1'b0;
        end
        if (do_swap) begin
            board_d[blank_q] = board_q[nb.idx];
            board_d[nb.idx]  = BLANK;
            blank_d          = TW'(nb.idx);
        end
    end

    // State registers; reset restores the solved board with the blank in the last cell.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < N; i++) board_q[i] <= TW'(i);
            blank_q     <= BLANK;
            move_cnt_q  <= '0;
            ini_q       <= 1'b0;
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
            scan_q      <= '0;
            bcnt_q      <= '0;
            fpos_q      <= '0;
            shuf_load_q <= 1'b0;
            shuf_cnt_q  <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            blank_q     <= blank_d;
            move_cnt_q  <= move_cnt_d;
            ini_q       <= ini_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            scan_q      <= scan_d;
            bcnt_q      <= bcnt_d;
            fpos_q      <= fpos_d;
            shuf_load_q <= shuf_load_d;
            shuf_cnt_q  <= shuf_cnt_d;
            prev_q      <= prev_d;
        end
    end

    // Flatten the board with cell 0 in the MSBs.
    always_comb begin
        out_game = '0;
        for (int i = 0; i < N; i++) out_game[(N-1-i)*TW +: TW] = board_q[i];
    end

    assign busy       = (state_q == StFind) || (state_q == StShuffle);
    assign win_flag   = (state_q == StWon);
    assign ini_flag   = ini_q;
    assign bad_move   = bad_q;
    assign load_err   = err_q;
    assign blank_pos  = blank_q;
    assign move_count = move_cnt_q;

endmodule
